// File: rtl/ps2_tx.sv
// ps2_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device (keyboard), e.g. 0xED set-LEDs,
// 0xFF reset, 0xF3 typematic. Both bus lines are open-drain: an *_oe output
// of 1 pulls the line low and 0 releases it. The top level maps each pin as
// `oe ? 1'b0 : 1'bz` and gates the receive path while busy is high.
//
// Ports:
//   clock        in   system clock (25 MHz)
//   reset_n      in   asynchronous reset, active low
//   send         in   one-cycle transmit request, accepted only while busy=0
//   data[7:0]    in   byte to transmit, sampled when send is accepted
//   ps_clock_i   in   PS/2 CLK pin level
//   ps_data_i    in   PS/2 DATA pin level
//   ps_clock_oe  out  1 = pull CLK low
//   ps_data_oe   out  1 = pull DATA low
//   busy         out  high from accept until the done cycle (inclusive)
//   done         out  one-cycle pulse at the end of a transfer
//   nack         out  device did not acknowledge; held until next accept
//   timeout      out  start or transfer timeout; held until next accept
module ps2_tx #(
  parameter int INHIBIT_CYC = 3000,
  parameter int START_TMO   = 375000,
  parameter int XFER_TMO    = 50000,
  parameter int FILT        = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       ps_clock_i,
  input  logic       ps_data_i,
  output logic       ps_clock_oe,
  output logic       ps_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout
);

  localparam int TMR_MAX = (INHIBIT_CYC > START_TMO) ?
                           ((INHIBIT_CYC > XFER_TMO) ? INHIBIT_CYC : XFER_TMO) :
                           ((START_TMO > XFER_TMO) ? START_TMO : XFER_TMO);
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int FW = $clog2(FILT + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RELEASE, BITS, ACK, WAITIDLE, FAIL, DONE
  } state_t;

  // Saturating increment: the timer parks at all-ones rather than wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Frame shifted out LSB first: data[7:0], odd parity, stop (released).
  function automatic logic [9:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  logic          clk_p0, clk_p1;
  logic          dat_p0, dat_p1;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [3:0]    bitcnt;
  logic [9:0]    frame;

  // Stage p0/p1: two-flop synchronizers; both lines idle high.
  // Stage p2: CLK glitch filter, a new level is accepted after FILT
  // consecutive samples that differ from the current filtered level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      dat_p0   <= 1'b1;
      dat_p1   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_p0 <= ps_clock_i;
      clk_p1 <= clk_p0;
      dat_p0 <= ps_data_i;
      dat_p1 <= dat_p0;
      fall   <= 1'b0;
      if (clk_p1 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT - 1)) begin
        clk_filt <= clk_p1;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Transfer FSM. tmr is shared: inhibit length, then start timeout in
  // RELEASE, then the transfer timeout from the first device fall onwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tmr         <= '0;
      bitcnt      <= '0;
      frame       <= '0;
      ps_clock_oe <= 1'b0;
      ps_data_oe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nack        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            frame       <= make_frame(data);
            nack        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            ps_clock_oe <= 1'b1;
            tmr         <= '0;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (tmr == TW'(INHIBIT_CYC - 1)) begin
            // Start bit goes out one cycle before CLK is released.
            ps_data_oe <= 1'b1;
            tmr        <= '0;
            state      <= RELEASE;
          end else begin
            tmr <= sat_inc(tmr);
          end
        end

        RELEASE: begin
          ps_clock_oe <= 1'b0;
          if (fall) begin
            // The first device fall already presents data bit 0.
            ps_data_oe <= ~frame[0];
            bitcnt     <= 4'd1;
            tmr        <= '0;
            state      <= BITS;
          end else if (tmr >= TW'(START_TMO - 1)) begin
            timeout <= 1'b1;
            state   <= FAIL;
          end else begin
            tmr <= sat_inc(tmr);
          end
        end

        BITS: begin
          if (tmr >= TW'(XFER_TMO - 1)) begin
            timeout <= 1'b1;
            state   <= FAIL;
          end else begin
            tmr <= sat_inc(tmr);
            if (fall) begin
              ps_data_oe <= ~frame[bitcnt];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9) state <= ACK;
            end
          end
        end

        ACK: begin
          if (tmr >= TW'(XFER_TMO - 1)) begin
            timeout <= 1'b1;
            state   <= FAIL;
          end else begin
            tmr <= sat_inc(tmr);
            if (fall) begin
              nack  <= dat_p1;
              state <= WAITIDLE;
            end
          end
        end

        WAITIDLE: begin
          if (tmr >= TW'(XFER_TMO - 1)) begin
            timeout <= 1'b1;
            state   <= FAIL;
          end else begin
            tmr <= sat_inc(tmr);
            if (clk_filt && dat_p1) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        FAIL: begin
          ps_clock_oe <= 1'b0;
          ps_data_oe  <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          // busy stays high through the done cycle so a coincident send
          // is not accepted.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int IC = 300;
  localparam int ST = 4000;
  localparam int XT = 3000;
  localparam int FL = 8;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       send    = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps_clock_i, ps_data_i;
  logic       ps_clock_oe, ps_data_oe, busy, done, nack, timeout;

  // Wired-AND open-drain bus between host and device model.
  assign ps_clock_i = dev_clk & ~ps_clock_oe;
  assign ps_data_i  = dev_dat & ~ps_data_oe;

  always #20 clock = ~clock;

  ps2_tx #(.INHIBIT_CYC(IC), .START_TMO(ST), .XFER_TMO(XT), .FILT(FL)) dut (
    .clock(clock), .reset_n(reset_n), .send(send), .data(data),
    .ps_clock_i(ps_clock_i), .ps_data_i(ps_data_i),
    .ps_clock_oe(ps_clock_oe), .ps_data_oe(ps_data_oe),
    .busy(busy), .done(done), .nack(nack), .timeout(timeout)
  );

  typedef struct packed {
    logic [9:0] bits;
    logic       nack;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] obs_bits = '0;
  int         vectors = 0;
  int         miscompares = 0;

  // Reference frame as seen on the wire: data LSB first, then a parity bit
  // making the total count of ones odd, then a high stop bit.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("nack", 32'(nack), 32'(e.nack));
          chk("timeout", 32'(timeout), 32'(e.tmo));
          chk("busy_at_done", 32'(busy), 32'd1);
          if (!e.tmo) chk("frame_bits", 32'(obs_bits), 32'(e.bits));
          else        chk("oe_released", 32'({ps_clock_oe, ps_data_oe}), 32'd0);
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_send(input logic [7:0] b, input bit expect_frame,
                         input logic exp_nack, input logic exp_tmo);
    exp_t e;
    @(negedge clock);
    send = 1'b1;
    data = b;
    if (expect_frame) begin
      e.bits = ref_frame(b);
      e.nack = exp_nack;
      e.tmo  = exp_tmo;
      sb.push_back(e);
    end
    @(negedge clock);
    send = 1'b0;
    data = 8'($urandom);
    chk("clk_oe_latency", 32'(ps_clock_oe), 32'd1);
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("flags_cleared", 32'({nack, timeout}), 32'd0);
  endtask

  // Device model. mode: 0 ack, 1 nack, 2 silent, 3 CLK glitch,
  // 4 second send mid-frame, 5 reset at bit 4.
  task automatic device(input int mode, input int h);
    int         n;
    logic       prev_dat;
    logic [9:0] bits;
    int         rem;
    bits     = '0;
    prev_dat = 1'b0;
    n = 0;
    while (ps_clock_oe === 1'b1 && n < IC + 20) begin
      prev_dat = ps_data_oe;
      n++;
      @(negedge clock);
    end
    chk("inhibit_len_ok", 32'(n >= IC - 1 && n <= IC + 1), 32'd1);
    chk("start_before_release", 32'(prev_dat), 32'd1);
    if (mode == 2) begin
      n = 0;
      while (done !== 1'b1 && n < ST + 50) begin
        @(negedge clock);
        n++;
      end
      chk("start_tmo_len_ok", 32'(n >= ST - 2 && n <= ST + 2), 32'd1);
      @(negedge clock);
      @(negedge clock);
      chk("busy_drops_tmo", 32'(busy), 32'd0);
      return;
    end
    repeat (30) @(negedge clock);
    chk("start_bit_on_line", 32'(ps_data_i), 32'd0);
    for (int p = 0; p < 11; p++) begin
      if (p == 10 && mode != 1) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (h) @(negedge clock);
      dev_clk = 1'b1;
      if (mode == 5 && p == 4) begin
        #3 reset_n = 1'b0;
        #1;
        chk("rst_clk_oe", 32'(ps_clock_oe), 32'd0);
        chk("rst_data_oe", 32'(ps_data_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      if (mode == 3 && p == 4) begin
        repeat (5) @(negedge clock);
        dev_clk = 1'b0;
        repeat (3) @(negedge clock);
        dev_clk = 1'b1;
        repeat (h / 2 - 8) @(negedge clock);
      end else begin
        repeat (h / 2) @(negedge clock);
      end
      if (p < 10) bits[p] = ps_data_i;
      rem = h - h / 2;
      if (mode == 4 && p == 2) begin
        send = 1'b1;
        data = 8'hAA;
        @(negedge clock);
        send = 1'b0;
        chk("busy_mid_frame", 32'(busy), 32'd1);
        rem = rem - 1;
      end
      repeat (rem) @(negedge clock);
      if (p == 9) obs_bits = bits;
    end
    dev_dat = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("busy_drops", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({ps_clock_oe, ps_data_oe, busy, done, nack, timeout}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    do_send(8'hED, 1'b1, 1'b0, 1'b0);
    device(0, 40);
    chk("ed_wire_bits", 32'(obs_bits), 32'h3ED);

    do_send(8'h00, 1'b1, 1'b0, 1'b0);
    device(0, 40);
    chk("zero_wire_bits", 32'(obs_bits), 32'h300);

    do_send(8'h01, 1'b1, 1'b0, 1'b0);
    device(0, 36);
    chk("one_wire_bits", 32'(obs_bits), 32'h201);

    do_send(8'h55, 1'b1, 1'b0, 1'b1);
    device(2, 40);

    do_send(8'h3C, 1'b1, 1'b1, 1'b0);
    device(1, 40);
    repeat (20) @(negedge clock);
    chk("nack_held", 32'(nack), 32'd1);

    do_send(8'h5A, 1'b1, 1'b0, 1'b0);
    device(4, 44);

    b = 8'($urandom);
    do_send(b, 1'b1, 1'b0, 1'b0);
    device(3, 40);

    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      do_send(b, 1'b1, 1'b0, 1'b0);
      device(0, int'($urandom_range(50, 30)));
    end

    do_send(8'h00, 1'b0, 1'b0, 1'b0);
    device(5, 40);
    repeat (20) @(negedge clock);
    chk("post_reset_idle", 32'({ps_clock_oe, ps_data_oe, busy}), 32'd0);

    b = 8'($urandom);
    do_send(b, 1'b1, 1'b0, 1'b0);
    device(0, 40);

    repeat (50) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("no_extra_frame", 32'({ps_clock_oe, busy}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
